// File: rtl/fisr_pkg.sv
// Shared definitions for the fast inverse square root pipeline stages:
// float32 field widths, bias, special constants and the result class.
package fisr_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int          BIAS   = 127;

    localparam logic [FP_W-1:0] FP_INF_POS = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    // Denormals count as zero; an input NaN is treated like infinity.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] ea,
                                           input logic [EXP_W-1:0] eb);
        logic a_max, b_max, a_zero, b_zero;
        a_max  = (ea == '1);
        b_max  = (eb == '1);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        if (a_max || b_max)
            return (a_zero || b_zero) ? CLS_NAN : CLS_INF;
        else if (a_zero || b_zero)
            return CLS_ZERO;
        else
            return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/newton_multiply_if.sv
// Operand/result bundle of the Newton multiply stage, including the
// global stall that freezes the pipeline.
interface newton_multiply_if;
    import fisr_pkg::*;

    logic            valid_in;
    logic            stall;
    logic [FP_W-1:0] NumIn;
    logic [FP_W-1:0] Init;
    logic [FP_W-1:0] NumOut;
    logic            valid_out;

    modport master (
        output valid_in, stall, NumIn, Init,
        input  NumOut, valid_out
    );

    modport slave (
        input  valid_in, stall, NumIn, Init,
        output NumOut, valid_out
    );

endinterface

// File: rtl/fisr_mant_mul.sv
// Registered 24x24 unsigned mantissa multiplier with hold enable; kept
// separate so it can be retimed or mapped onto a DSP block.
module fisr_mant_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    output logic [47:0] o_p
);

    logic [47:0] r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_p <= '0;
        else if (i_en)
            r_p <= 48'(i_a) * 48'(i_b);
    end

    assign o_p = r_p;

endmodule

// File: rtl/newton_multiply.sv
// Final Newton-Raphson step: y' = y * (1.5 - 0.5*x*y^2) as a 3-stage
// truncating float32 multiplier with valid tracking and a global stall.
module newton_multiply
    import fisr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    newton_multiply_if.slave  bus
);

    logic                   w_en;
    logic [EXP_W-1:0]       w_ea;
    logic [EXP_W-1:0]       w_eb;
    logic                   w_sign;
    logic signed [9:0]      w_esum;
    fp_class_t              w_cls;
    logic [47:0]            w1_prod;

    logic                   r1_valid;
    logic                   r1_sign;
    logic signed [9:0]      r1_exp;
    fp_class_t              r1_cls;

    logic signed [9:0]      w2_exp;
    logic [MANT_W-1:0]      w2_mant;
    logic [FP_W-1:0]        w2_word;
    logic                   w_unused_lsb;

    logic                   r2_valid;
    logic                   r2_sign;
    fp_class_t              r2_cls;
    logic [FP_W-1:0]        r2_word;

    logic [FP_W-1:0]        w3_word;
    logic                   r3_valid;
    logic [FP_W-1:0]        r3_word;

    assign w_en   = ~bus.stall;
    assign w_ea   = bus.NumIn[30:23];
    assign w_eb   = bus.Init[30:23];
    assign w_sign = bus.NumIn[31] ^ bus.Init[31];
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'(BIAS);
    assign w_cls  = classify(w_ea, w_eb);

    // S1: product register lives inside the multiplier sub-module
    fisr_mant_mul u_mant_mul (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_en),
        .i_a   ({1'b1, bus.NumIn[MANT_W-1:0]}),
        .i_b   ({1'b1, bus.Init[MANT_W-1:0]}),
        .o_p   (w1_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_cls   <= CLS_NORMAL;
        end else if (w_en) begin
            r1_valid <= bus.valid_in;
            r1_sign  <= w_sign;
            r1_exp   <= w_esum;
            r1_cls   <= w_cls;
        end
    end

    // S2: normalise, then clamp to infinity / zero (no denormal outputs)
    assign w_unused_lsb = ^w1_prod[22:0];

    always_comb begin
        w2_exp  = r1_exp + (w1_prod[47] ? 10'sd1 : 10'sd0);
        w2_mant = w1_prod[47] ? w1_prod[46:24] : w1_prod[45:23];
        if (w2_exp >= 10'sd255)
            w2_word = {r1_sign, 8'hFF, 23'h0};
        else if (w2_exp <= 10'sd0)
            w2_word = {r1_sign, 31'h0};
        else
            w2_word = {r1_sign, w2_exp[7:0], w2_mant};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_cls   <= CLS_NORMAL;
            r2_word  <= '0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_cls   <= r1_cls;
            r2_word  <= w2_word;
        end
    end

    // S3: special-operand classes override the arithmetic result
    always_comb begin
        w3_word = r2_word;
        case (r2_cls)
            CLS_ZERO: w3_word = {r2_sign, 31'h0};
            CLS_INF:  w3_word = {r2_sign, FP_INF_POS[30:0]};
            CLS_NAN:  w3_word = FP_QNAN;
            default:  w3_word = r2_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r3_valid <= 1'b0;
            r3_word  <= '0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            r3_word  <= w3_word;
        end
    end

    assign bus.NumOut    = r3_word;
    assign bus.valid_out = r3_valid;

endmodule

// File: tb/tb_newton_multiply.sv
// Self-checking bench for newton_multiply: directed products, specials,
// stall freeze, asynchronous reset and a randomized run against a model.
module tb_newton_multiply;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    newton_multiply_if bus ();

    newton_multiply dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] d;
        int          idx;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ns_cnt  = 0;
    int          n_vin   = 0;
    int          n_vout  = 0;
    logic        g_use_dir = 1'b0;
    logic [31:0] g_dir_exp = '0;

    // Value-level model: exact integer product, renormalised to 24 bits, truncated.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, sh;
        logic            s;
        longint unsigned ma, mb, p;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255) begin
            if (ea == 0 || eb == 0) return 32'h7FC0_0000;
            return {s, 8'hFF, 23'h0};
        end
        if (ea == 0 || eb == 0) return {s, 31'h0};
        ma = 64'(a[22:0]) + 64'h80_0000;
        mb = 64'(b[22:0]) + 64'h80_0000;
        p  = ma * mb;
        sh = 0;
        while ((p >> sh) >= 64'h100_0000) sh++;
        e = ea + eb - 127 + (sh - 23);
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, 8'(e), 23'((p >> sh) & 64'h7F_FFFF)};
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic st);
        bus.valid_in = v;
        bus.NumIn    = a;
        bus.Init     = b;
        bus.stall    = st;
    endtask

    // One clock: model the sampling edge, then check the outputs #1 after it.
    task automatic cycle(input string tag);
        logic        pv, st, vi, ue;
        logic [31:0] pd, a, b, de;
        exp_t        e;
        pv = bus.valid_out;
        pd = bus.NumOut;
        st = bus.stall;
        vi = bus.valid_in;
        a  = bus.NumIn;
        b  = bus.Init;
        ue = g_use_dir;
        de = g_dir_exp;
        @(posedge clk);
        #1;
        if (st) begin
            chk({tag, "_stall_valid"}, 32'(bus.valid_out), 32'(pv));
            chk({tag, "_stall_data"}, bus.NumOut, pd);
        end else begin
            if (vi) begin
                e.d   = ue ? de : ref_mul(a, b);
                e.idx = ns_cnt;
                q.push_back(e);
                n_vin++;
            end
            ns_cnt++;
            if (bus.valid_out === 1'b1) begin
                n_vout++;
                if (q.size() == 0) begin
                    chk({tag, "_spurious_valid"}, 32'(bus.valid_out), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({tag, "_data"}, bus.NumOut, e.d);
                    chk({tag, "_latency"}, 32'(ns_cnt - e.idx), 32'd3);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        bus.valid_in = 1'b0;
        bus.stall    = 1'b0;
        repeat (6) cycle(tag);
        chk({tag, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    logic [31:0] dir_a [11] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 32'h3F800000,
                                32'hBFC00000, 32'h00000000, 32'h80000000, 32'h7F000000,
                                32'h7F800000, 32'h00800000, 32'h40000000};
    logic [31:0] dir_b [11] = '{32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h3F000000,
                                32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                                32'h00000000, 32'h00800000, 32'h7F800000};
    logic [31:0] dir_e [11] = '{32'h40400000, 32'h3F800000, 32'h40100000, 32'h3F000000,
                                32'hC0400000, 32'h00000000, 32'h80000000, 32'h7F800000,
                                32'h7FC00000, 32'h00000000, 32'h7F800000};

    initial begin
        logic [31:0] sa [6];
        logic [31:0] sb [6];
        int          vin0, vout0, iter;

        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #17;
        chk("reset_valid", 32'(bus.valid_out), 32'd0);
        chk("reset_data", bus.NumOut, 32'd0);
        rst = 1'b1;

        // Directed products and special operands, back to back
        g_use_dir = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, dir_a[i], dir_b[i], 1'b0);
            g_dir_exp = dir_e[i];
            cycle($sformatf("dir%0d", i));
        end
        g_use_dir = 1'b0;
        drain("dir_drain");

        // Six back-to-back items with a 4-cycle stall after the third
        for (int i = 0; i < 6; i++) begin
            sa[i] = rand_normal();
            sb[i] = rand_normal();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sa[i], sb[i], 1'b0);
            cycle("stream");
        end
        repeat (4) begin
            drive(1'b1, sa[3], sb[3], 1'b1);
            cycle("stall");
        end
        for (int i = 3; i < 6; i++) begin
            drive(1'b1, sa[i], sb[i], 1'b0);
            cycle("stream");
        end
        drain("stall_drain");

        // Reset with two items in flight: outputs clear at once, items vanish
        drive(1'b1, 32'h3FC00000, 32'h40000000, 1'b0);
        cycle("pre_rst");
        drive(1'b1, 32'h3F800000, 32'h3F000000, 1'b0);
        cycle("pre_rst");
        bus.valid_in = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("async_rst_data", bus.NumOut, 32'd0);
        q.delete();
        #2;
        rst = 1'b1;
        repeat (4) cycle("post_rst_idle");
        drive(1'b1, 32'hBFC00000, 32'h40000000, 1'b0);
        cycle("post_rst");
        drain("post_rst_drain");

        // Randomized normal operands with random bubbles and stalls
        vin0  = n_vin;
        vout0 = n_vout;
        iter  = 0;
        while ((n_vin - vin0) < 10000 && iter < 20000) begin
            drive(($urandom_range(0, 99) < 85), rand_normal(), rand_normal(),
                  ($urandom_range(0, 99) < 8));
            cycle("rand");
            iter++;
        end
        chk("rand_issued", 32'(n_vin - vin0), 32'd10000);
        drain("rand_drain");
        chk("valid_count", 32'(n_vout - vout0), 32'(n_vin - vin0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
